// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, scan-state type and anode helper for the 4-digit
// multiplexed seven-segment scanner.
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Active-low anode pattern with only the selected digit driven.
  function automatic logic [NUM_DIGITS-1:0] an_select(input logic [IDX_W-1:0] idx);
    an_select = ~(NUM_DIGITS'(1) << idx);
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit-write port plus display outputs of the scanner; the host drives
// the master side, the scanner sits on the slave side.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                  we;
  logic [IDX_W-1:0]      wsel;
  logic [DIGIT_W-1:0]    wdata;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [NUM_DIGITS-1:0] an;
  logic [DIGIT_W-1:0]    digit;
  logic [IDX_W-1:0]      dsel;
  logic                  frame_tick;

  modport master (
    output we, wsel, wdata, digit_en,
    input  an, digit, dsel, frame_tick
  );

  modport slave (
    input  we, wsel, wdata, digit_en,
    output an, digit, dsel, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl_prescaler.sv
// Slot timer: counts 0..DIV-1 and flags the slot wrap and the SHOW portion
// (count >= BLANK) of each digit slot.
module seg_prescaler #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [$clog2(DIV)-1:0]  cnt,
  output logic                    slot_wrap,
  output logic                    in_show
);
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (slot_wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign slot_wrap = (cnt_q == CNT_W'(DIV - 1));
  assign in_show   = (cnt_q >= CNT_W'(BLANK));
endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit display scanner: digit register bank, BLANK/SHOW slot FSM and
// registered anode/digit/index/frame outputs.
module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);
  import seg_pkg::*;

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0]      cnt;
  logic                  slot_wrap;
  logic                  in_show;
  logic [NUM_DIGITS-1:0] wr_hit;
  logic [DIGIT_W-1:0]    bank_q [NUM_DIGITS];
  scan_state_e           state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [DIGIT_W-1:0]    digit_q;
  logic [IDX_W-1:0]      dsel_q;
  logic                  frame_q;

  seg_prescaler #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .cnt       (cnt),
    .slot_wrap (slot_wrap),
    .in_show   (in_show)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_wr_dec
    assign wr_hit[gi] = bus.we && (bus.wsel == IDX_W'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (rst) begin
        bank_q[i] <= '0;
      end else if (wr_hit[i]) begin
        bank_q[i] <= bus.wdata;
      end
    end
  end

  // Outputs sample the pre-edge index and bank, so a write at one edge
  // reaches digit at the next edge even across a slot change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= seg_pkg::BLANK;
      idx_q   <= '0;
      an_q    <= AN_OFF;
      digit_q <= '0;
      dsel_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      case (state_q)
        seg_pkg::BLANK: if (cnt == CNT_W'(BLANK - 1)) state_q <= seg_pkg::SHOW;
        seg_pkg::SHOW:  if (slot_wrap)                state_q <= seg_pkg::BLANK;
        default:                                      state_q <= seg_pkg::BLANK;
      endcase
      if (slot_wrap) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if ((state_q == seg_pkg::SHOW) && in_show && bus.digit_en[idx_q]) begin
        an_q <= an_select(idx_q);
      end else begin
        an_q <= AN_OFF;
      end
      digit_q <= bank_q[idx_q];
      dsel_q  <= idx_q;
      frame_q <= slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
    end
  end

  assign bus.an         = an_q;
  assign bus.digit      = digit_q;
  assign bus.dsel       = dsel_q;
  assign bus.frame_tick = frame_q;
endmodule
